// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: request, ALU and response buses; ALU_ARB_FLAGS_EN adds rsp_zero/rsp_carry
interface alu_req_arbiter_if #(parameter int WIDTH = 4);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic alu_s0, alu_s1, alu_s3;
  logic [WIDTH:0] alu_out, rsp_data;
  logic rsp_valid, rsp_ready, rsp_id;
`ifdef ALU_ARB_FLAGS_EN
  logic rsp_zero, rsp_carry;
`endif
  modport slave (
    input req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s3, rsp_valid, rsp_data, rsp_id
`ifdef ALU_ARB_FLAGS_EN
    , rsp_zero, rsp_carry
`endif
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, alu_out, rsp_ready,
    input req0_ready, req1_ready, alu_a, alu_b, alu_s0, alu_s1, alu_s3, rsp_valid, rsp_data, rsp_id
`ifdef ALU_ARB_FLAGS_EN
    , rsp_zero, rsp_carry
`endif
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU between two requesters
// Optional ALU_ARB_FLAGS_EN registers rsp_zero/rsp_carry alongside the captured result.
module alu_req_arbiter #(
  parameter int WIDTH = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  alu_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next_state;
  logic last, gnt1, hs;
  logic [3:0] cnt;
  // last holds the id granted most recently; a tie goes to the other one
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last);
  assign hs = bus.req0_ready | bus.req1_ready;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (hs ? EXEC : IDLE) :
                 state == EXEC ? (cnt == 4'd1 ? RESP : EXEC) :
                 (bus.rsp_ready ? IDLE : RESP);
  always_comb begin
    bus.req0_ready = !rst && state == IDLE && bus.req0_valid && !gnt1;
    bus.req1_ready = !rst && state == IDLE && gnt1;
    bus.rsp_valid = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
      cnt <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      {bus.alu_s3, bus.alu_s0, bus.alu_s1} <= 3'b000;
      bus.rsp_id <= 1'b0;
      bus.rsp_data <= '0;
`ifdef ALU_ARB_FLAGS_EN
      bus.rsp_zero <= 1'b0;
      bus.rsp_carry <= 1'b0;
`endif
    end else begin
      if (hs) begin
        last <= gnt1;
        bus.rsp_id <= gnt1;
        {bus.alu_s3, bus.alu_s0, bus.alu_s1} <= gnt1 ? bus.req1_op : bus.req0_op;
        bus.alu_a <= gnt1 ? bus.req1_a : bus.req0_a;
        bus.alu_b <= gnt1 ? bus.req1_b : bus.req0_b;
        cnt <= 4'(SETTLE_CYCLES);
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          bus.rsp_data <= bus.alu_out;
`ifdef ALU_ARB_FLAGS_EN
          bus.rsp_zero <= bus.alu_out[WIDTH-1:0] == '0;
          bus.rsp_carry <= bus.alu_out[WIDTH];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and random traffic checked against a transaction-level model
module tb_alu_req_arbiter;
  localparam int W = 4, S = 1, SX = 3;
  logic clk = 0, rst = 1;
  bit mon = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.WIDTH(W)) bi();
  alu_req_arbiter_if #(.WIDTH(W)) bx();
  alu_req_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .bus(bi));
  alu_req_arbiter #(.WIDTH(W), .SETTLE_CYCLES(SX)) dut_x (.clk(clk), .rst(rst), .bus(bx));

  function automatic logic [4:0] ref_alu(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {a >= b, 4'(a - b)};
      3'd2: return {1'b0, a} + 5'd1;
      3'd3: return {a != 4'd0, 4'(a - 4'd1)};
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a ^ b};
      default: return {2'b00, a[3:1]};
    endcase
  endfunction

  assign bi.alu_out = ref_alu({bi.alu_s3, bi.alu_s0, bi.alu_s1}, bi.alu_a, bi.alu_b);
  assign bx.alu_out = ref_alu({bx.alu_s3, bx.alu_s0, bx.alu_s1}, bx.alu_a, bx.alu_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic m_idle, m_resp, m_last, m_rid;
  int m_wait;
  logic [2:0] m_op;
  logic [3:0] m_a, m_b;
  logic [4:0] m_exp, m_rdata;
  wire e0 = !rst && m_idle && bi.req0_valid && (!bi.req1_valid || m_last);
  wire e1 = !rst && m_idle && bi.req1_valid && (!bi.req0_valid || !m_last);

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1; m_resp <= 0; m_last <= 1; m_rid <= 0;
      m_op <= 0; m_a <= 0; m_b <= 0; m_rdata <= 0; m_wait <= 0;
    end else if (e0 || e1) begin
      m_idle <= 0; m_wait <= S; m_last <= e1; m_rid <= e1;
      m_op <= e1 ? bi.req1_op : bi.req0_op;
      m_a <= e1 ? bi.req1_a : bi.req0_a;
      m_b <= e1 ? bi.req1_b : bi.req0_b;
      m_exp <= e1 ? ref_alu(bi.req1_op, bi.req1_a, bi.req1_b) : ref_alu(bi.req0_op, bi.req0_a, bi.req0_b);
    end else if (!m_idle && !m_resp) begin
      if (m_wait == 1) begin
        m_resp <= 1; m_rdata <= m_exp;
      end else m_wait <= m_wait - 1;
    end else if (m_resp && bi.rsp_ready) begin
      m_resp <= 0; m_idle <= 1;
    end
  end

  always @(negedge clk) if (mon) begin
    chk("req0_ready", bi.req0_ready, e0);
    chk("req1_ready", bi.req1_ready, e1);
    chk("rsp_valid", bi.rsp_valid, m_resp);
    chk("rsp_data", bi.rsp_data, m_rdata);
    chk("rsp_id", bi.rsp_id, m_rid);
    chk("alu_a", bi.alu_a, m_a);
    chk("alu_b", bi.alu_b, m_b);
    chk("alu_sel", {bi.alu_s3, bi.alu_s0, bi.alu_s1}, m_op);
`ifdef ALU_ARB_FLAGS_EN
    chk("rsp_zero", bi.rsp_zero, m_rdata[3:0] == 4'd0);
    chk("rsp_carry", bi.rsp_carry, m_rdata[4]);
`endif
  end

  task automatic tx(input bit id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                    input logic [4:0] exp, input string tag);
    int n = 0;
    if (id) begin bi.req1_valid = 1; bi.req1_op = op; bi.req1_a = a; bi.req1_b = b; end
    else begin bi.req0_valid = 1; bi.req0_op = op; bi.req0_a = a; bi.req0_b = b; end
    do @(negedge clk); while (!(id ? bi.req1_ready : bi.req0_ready) && ++n < 20);
    chk({tag, "_hs"}, n < 20, 1);
    @(posedge clk); #1;
    bi.req0_valid = 0; bi.req1_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bi.rsp_valid && n < 20);
    chk({tag, "_lat"}, n, S + 1);
    chk({tag, "_data"}, bi.rsp_data, exp);
    chk({tag, "_id"}, bi.rsp_id, id);
`ifdef ALU_ARB_FLAGS_EN
    chk({tag, "_zero"}, bi.rsp_zero, exp[3:0] == 4'd0);
    chk({tag, "_carry"}, bi.rsp_carry, exp[4]);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    logic [4:0] d;
    bit a0, a1;
    {bi.req0_valid, bi.req1_valid, bx.req0_valid, bx.req1_valid} = '0;
    {bi.req0_op, bi.req1_op, bx.req0_op, bx.req1_op} = '0;
    {bi.req0_a, bi.req0_b, bi.req1_a, bi.req1_b} = '0;
    {bx.req0_a, bx.req0_b, bx.req1_a, bx.req1_b} = '0;
    bi.rsp_ready = 1; bx.rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0; mon = 1;
    @(negedge clk);
    chk("x_rst_rsp_valid", bx.rsp_valid, 0);
    chk("x_rst_alu_a", bx.alu_a, 0);
    @(posedge clk); #1;
    // both requesters always valid: grants must alternate starting with req0
    bi.req0_valid = 1; bi.req0_op = 0; bi.req0_a = 3; bi.req0_b = 5;
    bi.req1_valid = 1; bi.req1_op = 6; bi.req1_a = 9; bi.req1_b = 12;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do @(negedge clk); while (!(bi.req0_ready || bi.req1_ready) && ++n < 20);
      chk("rr_hs", n < 20, 1);
      chk("rr_grant", bi.req1_ready, i % 2);
      chk("rr_one_ready", bi.req0_ready & bi.req1_ready, 0);
      @(posedge clk); #1;
      if (i % 2) begin bi.req1_op = 3'(i + 2); bi.req1_a = 4'(i * 5); end
      else begin bi.req0_op = 3'(i + 1); bi.req0_a = 4'(i * 3 + 7); end
      n = 0;
      do @(negedge clk); while (!bi.rsp_valid && ++n < 20);
      chk("rr_rsp_id", bi.rsp_id, i % 2);
      @(posedge clk); #1;
    end
    bi.req0_valid = 0; bi.req1_valid = 0;
    @(posedge clk); #1;
    tx(0, 3'b000, 4'b1011, 4'b1111, 5'b11010, "add");
    tx(1, 3'b001, 4'b1011, 4'b1111, 5'b01100, "sub");
    tx(0, 3'b010, 4'b1111, 4'b0000, 5'b10000, "inc");
    tx(0, 3'b011, 4'b0000, 4'b0000, 5'b01111, "dec");
    tx(0, 3'b111, 4'b1011, 4'b0000, 5'b00101, "shr");
    tx(0, 3'b110, 4'b1011, 4'b1111, 5'b00100, "xor");
    tx(0, 3'b100, 4'b1011, 4'b0110, 5'b00010, "and");
    tx(0, 3'b101, 4'b1000, 4'b0001, 5'b01001, "or");
    tx(1, 3'b001, 4'b0101, 4'b0101, 5'b10000, "sub_eq");
    // backpressure: response held while req1 waits
    bi.rsp_ready = 0;
    bi.req0_valid = 1; bi.req0_op = 3'b101; bi.req0_a = 4'b1000; bi.req0_b = 4'b0001;
    n = 0;
    do @(negedge clk); while (!bi.req0_ready && ++n < 20);
    chk("bp_hs", n < 20, 1);
    @(posedge clk); #1;
    bi.req0_valid = 0;
    bi.req1_valid = 1; bi.req1_op = 3'b000; bi.req1_a = 4'd1; bi.req1_b = 4'd2;
    n = 0;
    do @(negedge clk); while (!bi.rsp_valid && ++n < 20);
    d = bi.rsp_data;
    chk("bp_data", d, 5'b01001);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bi.rsp_valid, 1);
      chk("bp_stable", bi.rsp_data, d);
      chk("bp_ready", {bi.req0_ready, bi.req1_ready}, 0);
    end
    @(posedge clk); #1 bi.rsp_ready = 1;
    @(negedge clk);
    chk("bp_rel_valid", bi.rsp_valid, 1);
    chk("bp_rel_noacc", bi.req1_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_valid", bi.rsp_valid, 0);
    chk("bp_next_grant", bi.req1_ready, 1);
    @(posedge clk); #1 bi.req1_valid = 0;
    n = 0;
    do @(negedge clk); while (!bi.rsp_valid && ++n < 20);
    chk("bp_next_data", bi.rsp_data, 5'b00011);
    chk("bp_next_id", bi.rsp_id, 1);
    @(posedge clk); #1;
    // reset in the middle of EXEC on the SETTLE=3 instance
    bx.req0_valid = 1; bx.req0_op = 0; bx.req0_a = 5; bx.req0_b = 6;
    @(negedge clk);
    chk("x_hs", bx.req0_ready, 1);
    @(posedge clk); #1 bx.req0_valid = 0;
    @(negedge clk);
    chk("x_exec_alu_a", bx.alu_a, 5);
    @(posedge clk); #1 rst = 1; bx.req0_valid = 1; bx.req1_valid = 1;
    @(negedge clk);
    chk("x_rst_ready", {bx.req0_ready, bx.req1_ready}, 0);
    @(posedge clk); #1 rst = 0; bx.req0_valid = 0; bx.req1_valid = 0;
    @(negedge clk);
    chk("x_rst_alu", {bx.alu_a, bx.alu_b, bx.alu_s3, bx.alu_s0, bx.alu_s1}, 0);
    chk("x_rst_rsp", {bx.rsp_valid, bx.rsp_data, bx.rsp_id}, 0);
`ifdef ALU_ARB_FLAGS_EN
    chk("x_rst_flags", {bx.rsp_zero, bx.rsp_carry}, 0);
`endif
    repeat (SX + 2) begin
      @(negedge clk);
      chk("x_no_rsp", bx.rsp_valid, 0);
    end
    @(posedge clk); #1 bx.req0_valid = 1; bx.req1_valid = 1; bx.req1_op = 2; bx.req1_a = 4;
    @(negedge clk);
    chk("x_tie_req0", {bx.req0_ready, bx.req1_ready}, 2'b10);
    @(posedge clk); #1 bx.req0_valid = 0; bx.req1_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bx.rsp_valid && n < 20);
    chk("x_lat", n, SX + 1);
    chk("x_data", bx.rsp_data, 5'd11);
    @(posedge clk); #1;
    // random traffic, every cycle checked by the model monitor
    a0 = 0; a1 = 0;
    repeat (600) begin
      if (a0) bi.req0_valid = 1'($urandom);
      else if (bi.req0_valid) begin if ($urandom % 8 == 0) bi.req0_valid = 0; end
      else bi.req0_valid = 1'($urandom);
      if (a1) bi.req1_valid = 1'($urandom);
      else if (bi.req1_valid) begin if ($urandom % 8 == 0) bi.req1_valid = 0; end
      else bi.req1_valid = 1'($urandom);
      if (a0 || !bi.req0_valid) begin bi.req0_op = 3'($urandom); bi.req0_a = 4'($urandom); bi.req0_b = 4'($urandom); end
      if (a1 || !bi.req1_valid) begin bi.req1_op = 3'($urandom); bi.req1_a = 4'($urandom); bi.req1_b = 4'($urandom); end
      bi.rsp_ready = ($urandom % 4) != 0;
      @(negedge clk);
      a0 = bi.req0_ready; a1 = bi.req1_ready;
      @(posedge clk); #1;
    end
    bi.req0_valid = 0; bi.req1_valid = 0; bi.rsp_ready = 1;
    repeat (10) @(posedge clk);
    #1 mon = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Sequencer and arbiter that shares one combinational gate-level `alu` (WIDTH-bit operands, WIDTH+1-bit result) between two requesters.
- Accepts operation requests over valid/ready and arbitrates round-robin.
- Registers the winner's operands, drives the ALU select lines, waits a fixed settle time, captures the result and returns it with the requester ID over a valid/ready response channel.
- Sits between the instruction/control logic and the shared ALU instance.

Parameters:
WIDTH, 4, operand width; equals the codebase NUM_BITS; result is WIDTH+1 bits.
SETTLE_CYCLES, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_op  input  3  opcode {s3,s0,s1} for requester 0.
req0_a  input  WIDTH  operand A, requester 0.
req0_b  input  WIDTH  operand B, requester 0.
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, requester 1.
alu_a  output  WIDTH  registered operand A to the ALU.
alu_b  output  WIDTH  registered operand B to the ALU.
alu_s0  output  1  ALU select s0.
alu_s1  output  1  ALU select s1.
alu_s3  output  1  ALU select s3 (1 = logic unit, 0 = arithmetic unit).
alu_out  input  WIDTH+1  ALU result; bit WIDTH is carry.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  WIDTH+1  captured ALU result.
rsp_id  output  1  requester that issued the operation.

Behaviour:
- Opcode {s3,s0,s1}:
  - 000 add, result = A+B with carry.
  - 001 sub, result = A+~B+1; carry=1 means no borrow.
  - 010 inc, result = A+1.
  - 011 dec, result = A+all-ones; carry=0 only when A=0.
  - 100 and, 101 or, 110 xor; carry bit 0 for all three.
  - 111 shr, result = A>>1 with zero fill; carry bit 0.
  - All 8 opcodes are legal.
- The ALU is external and purely combinational. Its selects are driven from the latched op bits.
- FSM states are IDLE, EXEC, RESP.
- IDLE:
  - req_ready of the granted requester is asserted combinationally when its valid=1. Ready is never asserted for both requesters.
  - On the handshake, latch op/a/b into the alu_* registers, record rsp_id, load the settle counter with SETTLE_CYCLES, then go to EXEC.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - The last-grant pointer updates only on a completed handshake.
  - After reset the pointer favours req0 on the first tie.
- EXEC:
  - alu_* outputs are held stable and the counter decrements each cycle.
  - In the cycle the counter reaches 1, alu_out is captured into rsp_data at the clock edge and the FSM goes to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable. Both req_ready are 0.
  - When rsp_ready=1, go to IDLE. rsp_valid drops the next cycle.
- Latency: handshake in cycle t gives rsp_valid=1 in cycle t+SETTLE_CYCLES+1. Default: t+2.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles. No accept in the cycle the response completes.
- Backpressure: rsp_ready held low stalls in RESP indefinitely. Requests wait and are never dropped.
- Requester rules: a requester may drop valid before ready without penalty. Operands are sampled only on the handshake.
- Reset, synchronous, applies from any state including mid-EXEC or RESP:
  - state = IDLE.
  - rsp_valid, rsp_data, rsp_id, alu_a, alu_b, alu_s0/s1/s3 all = 0 (ALU idles on add 0+0).
  - pointer favours req0.
  - req0_ready and req1_ready are forced 0 while rst=1.
  - An in-flight operation is discarded with no response.

Optional Feature:
- Macro: ALU_ARB_FLAGS_EN.
- Defined: adds outputs rsp_zero (1 when rsp_data[WIDTH-1:0]==0) and rsp_carry (= rsp_data[WIDTH]).
  - Both are registered at capture, valid with rsp_valid, reset to 0.
- Undefined: these ports and their flops do not exist. All other behaviour is identical.

Test Plan:
- Only req0: op=000, a=1011, b=1111 -> rsp_valid 2 cycles after handshake, rsp_data=11010, rsp_id=0.
- Only req1: op=001, a=1011, b=1111 -> rsp_data=01100, rsp_id=1. With flags: rsp_carry=0, rsp_zero=0.
- Op sweep on req0: inc a=1111 -> 10000; dec a=0000 -> 01111; shr a=1011 -> 00101; xor 1011^1111 -> 00100; and 1011&0110 -> 00010.
- Both valid continuously with distinct ops for 4 transactions, rsp_ready=1 -> rsp_id sequence 0,1,0,1; never both ready high.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, both req_ready=0; release -> IDLE next cycle, next grant proceeds.
- rst asserted in EXEC, SETTLE_CYCLES=3 -> next cycle all outputs 0, no response emitted, first post-reset tie grants req0.
